// File: rtl/watch_pkg.sv
// Shared constants for the watch top level: button ordering, mode slot
// indices and the step-direction type used by the mode sequencer.
package watch_pkg;

  // Button positions inside the clean button vector {esc,enter,right,left,down,up}.
  localparam int N_BTN     = 6;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  // Mode slot indices of the standard watch build.
  localparam int M_DATE      = 0;
  localparam int M_CLOCK     = 1;
  localparam int M_ALARM     = 2;
  localparam int M_STOPWATCH = 3;
  localparam int M_TIMER     = 4;
  localparam int M_DDAY      = 5;
  localparam int M_LADDER    = 6;

  // Requested ring step for the current cycle.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

endpackage

// File: rtl/mode_sequencer_if.sv
// Bus between the mode sequencer and the per-mode function blocks.
// The sequencer is the master: it receives enables, idle flags, display
// buses and alarms, and publishes the active mode and muxed display.
interface mode_sequencer_if #(
  parameter int N_MODES = 7,
  parameter int OUT_W   = 48
);

  logic [N_MODES-1:0]       mode_en;
  logic [N_MODES-1:0]       norm;
  logic [N_MODES*OUT_W-1:0] sub_out;
  logic [N_MODES-1:0]       sub_alarm;
  logic [N_MODES-1:0]       mode;
  logic [7:0]               o_m;
  logic [OUT_W-1:0]         out;
  logic                     alarm;

  modport master (
    input  mode_en, norm, sub_out, sub_alarm,
    output mode, o_m, out, alarm
  );

  modport slave (
    output mode_en, norm, sub_out, sub_alarm,
    input  mode, o_m, out, alarm
  );

endinterface

// File: rtl/btn_sync.sv
// Front-end for one active-low push button: two-flop synchroniser, a
// "seen released" arm flag so a button held through reset stays silent,
// rising-edge detection and optional auto-repeat while held.
module btn_sync #(
  parameter int REPEAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic step
);

  logic sync1;
  logic sync2;
  logic seen;
  logic prev;
  logic rise;

  // Synchronise the inverted button, arm once released, remember last level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two-flop chain.
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      seen  <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= ~raw_n;
      sync2 <= sync1;
      if (!sync2) seen <= 1'b1;
      prev  <= level;
    end
  end

  assign level = sync2 & seen;
  assign rise  = level & ~prev;

  if (REPEAT > 0) begin : g_repeat
    localparam int            CW   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(REPEAT - 1);

    logic [CW-1:0] cnt;

    // Restart on a fresh press, count while held, wrap at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= '0;
      end else if (level) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end

    assign step = rise | (level & (cnt == LAST));
  end else begin : g_single
    assign step = rise;
  end

endmodule

// File: rtl/mode_sequencer.sv
// Watch front-end and mode controller: cleans the six buttons, steps a
// one-hot mode ring over enabled slots while the active block is idle,
// relocates off a disabled slot, muxes the display and merges alarms.
module mode_sequencer
  import watch_pkg::*;
#(
  parameter int N_MODES    = 7,
  parameter int OUT_W      = 48,
  parameter int RESET_MODE = 3,
  parameter int REPEAT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_n,
  input  logic             down_n,
  input  logic             left_n,
  input  logic             right_n,
  input  logic             enter_n,
  input  logic             esc_n,
  output logic [N_BTN-1:0] btn,
  mode_sequencer_if.master bus
);

  localparam int IW = (N_MODES > 1) ? $clog2(N_MODES) : 1;

  logic [N_BTN-1:0] raw_n;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] step;
  logic             unused_steps;

  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_next;
  logic [OUT_W-1:0] out_q;
  logic             alarm_q;
  logic             live;
  step_e            step_dir;

  assign raw_n = {esc_n, enter_n, right_n, left_n, down_n, up_n};

  // Only up/down auto-repeat; the other buttons report single presses.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    localparam int RPT = (i == BTN_UP || i == BTN_DOWN) ? REPEAT : 0;

    btn_sync #(.REPEAT(RPT)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (raw_n[i]),
      .level (level[i]),
      .step  (step[i])
    );
  end

  assign btn          = level;
  assign unused_steps = ^step[N_BTN-1:2];

  // Nearest enabled slot after cur in the given direction, wrapping; cur if none.
  function automatic logic [IW-1:0] next_enabled(
    input logic [IW-1:0]      cur,
    input logic [N_MODES-1:0] en,
    input logic               dir_up
  );
    logic [IW-1:0] res;
    logic          found;
    int            idx;
    res   = cur;
    found = 1'b0;
    for (int d = 1; d < N_MODES; d++) begin
      if (dir_up) idx = (int'(cur) + d) % N_MODES;
      else        idx = (int'(cur) + N_MODES - d) % N_MODES;
      if (!found && en[IW'(idx)]) begin
        res   = IW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Resolve the step request and pick the next active slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    step_dir = STEP_NONE;
    idx_next = idx_q;
    if (step[BTN_UP])        step_dir = STEP_UP;
    else if (step[BTN_DOWN]) step_dir = STEP_DOWN;

    if (!bus.mode_en[idx_q]) begin
      idx_next = next_enabled(idx_q, bus.mode_en, 1'b1);
    end else if (bus.norm[idx_q] && step_dir != STEP_NONE) begin
      idx_next = next_enabled(idx_q, bus.mode_en, step_dir == STEP_UP);
    end
  end

  // Mode index, display and alarm registers; the release edge only arms them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      idx_q   <= IW'(RESET_MODE);
      out_q   <= '0;
      alarm_q <= 1'b0;
    end else if (!live) begin
      live <= 1'b1;
    end else begin
      idx_q   <= idx_next;
      out_q   <= bus.mode_en[idx_q] ? bus.sub_out[int'(idx_q)*OUT_W +: OUT_W] : '0;
      alarm_q <= |(bus.sub_alarm & bus.mode_en);
    end
  end

  assign bus.mode  = N_MODES'(1) << idx_q;
  assign bus.o_m   = 8'(idx_q);
  assign bus.out   = out_q;
  assign bus.alarm = alarm_q;

endmodule
